// File: rtl/fpu_isa_pkg.sv
// Shared ISA definitions for the BFloat16 FPU fetch path: opcodes,
// instruction field positions, FPU operation encodings and FSM states.
package fpu_isa_pkg;

    // Instruction opcodes, bits [15:13]
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;

    // Field bit positions inside a 16-bit instruction word
    localparam int OPC_HI = 15;
    localparam int OPC_LO = 13;
    localparam int RD_HI  = 12;
    localparam int RD_LO  = 9;
    localparam int RS1_HI = 8;
    localparam int RS1_LO = 5;
    localparam int RS2_HI = 4;
    localparam int RS2_LO = 1;

    // Operation encodings presented to the FPU
    localparam logic [1:0] FOP_ADD = 2'b00;
    localparam logic [1:0] FOP_SUB = 2'b01;
    localparam logic [1:0] FOP_MUL = 2'b10;

    // Fetch-unit control states
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

    // Map an arithmetic opcode onto the FPU operation encoding
    function automatic logic [1:0] fop_of(input logic [2:0] opc);
        logic [1:0] fop;
        case (opc)
            OP_ADD:  fop = FOP_ADD;
            OP_SUB:  fop = FOP_SUB;
            OP_MUL:  fop = FOP_MUL;
            default: fop = FOP_ADD;
        endcase
        return fop;
    endfunction

endpackage

// File: rtl/instr_store.sv
// Instruction store: 2**AW words of IW bits, synchronous write,
// combinational read. Contents are deliberately not reset.
module instr_store #(
    parameter int IW = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [IW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [IW-1:0] rdata_o
);

    logic [IW-1:0] mem_q [2**AW];

    // Program load: write one word per strobed cycle
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch/decode/issue stage: reads the word addressed by the PC, decodes it
// and hands arithmetic operations to the FPU over a valid/ready handshake.
// Stalls the upstream PC counter under backpressure, HALT or program load.
module instr_fetch_unit
    import fpu_isa_pkg::*;
#(
    parameter int IW = 16,
    parameter int AW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [AW-1:0] pc_i,
    output logic          pc_en,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [IW-1:0] prog_data,
    input  logic          resume,
    output logic          issue_valid,
    input  logic          issue_ready,
    output logic [1:0]    issue_op,
    output logic [3:0]    issue_rd,
    output logic [3:0]    issue_rs1,
    output logic [3:0]    issue_rs2,
    output logic [AW-1:0] issue_pc,
    output logic          halted,
    output logic          illegal,
    output logic [CW-1:0] issued_cnt
);

    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    fetch_state_e  state_q, state_d;
    logic          valid_q, valid_d;
    logic [1:0]    op_q, op_d;
    logic [3:0]    rd_q, rd_d;
    logic [3:0]    rs1_q, rs1_d;
    logic [3:0]    rs2_q, rs2_d;
    logic [AW-1:0] ipc_q, ipc_d;
    logic          illegal_q, illegal_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] fetch_word_s;
    logic [2:0]    opc_s;
    logic          slot_free_s;
    logic          pc_en_s;
    logic          xfer_s;
    logic          unused_s;

    instr_store #(
        .IW (IW),
        .AW (AW)
    ) u_store (
        .clk     (clk),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_i),
        .rdata_o (fetch_word_s)
    );

    assign opc_s       = fetch_word_s[OPC_HI:OPC_LO];
    assign unused_s    = fetch_word_s[0];
    assign slot_free_s = !valid_q || issue_ready;
    assign xfer_s      = valid_q && issue_ready;
    // A program write steals the cycle so the store is never read mid-update
    assign pc_en_s     = (state_q == ST_RUN) && slot_free_s && !prog_we;

    // Next-state logic: decode, issue register, FSM, sticky flag and counter
    always_comb begin
        state_d   = state_q;
        valid_d   = valid_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        ipc_d     = ipc_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;

        if (xfer_s && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end

        if (pc_en_s) begin
            case (opc_s)
                OP_ADD, OP_SUB, OP_MUL: begin
                    valid_d = 1'b1;
                    op_d    = fop_of(opc_s);
                    rd_d    = fetch_word_s[RD_HI:RD_LO];
                    rs1_d   = fetch_word_s[RS1_HI:RS1_LO];
                    rs2_d   = fetch_word_s[RS2_HI:RS2_LO];
                    ipc_d   = pc_i;
                end
                OP_NOP: begin
                    valid_d = 1'b0;
                end
                OP_HALT: begin
                    // Resume on this same edge is ignored: we are still in RUN
                    valid_d = 1'b0;
                    state_d = ST_HALT;
                end
                default: begin
                    valid_d   = 1'b0;
                    illegal_d = 1'b1;
                end
            endcase
        end else begin
            if (xfer_s) begin
                valid_d = 1'b0;
            end else begin
                valid_d = valid_q;
            end
            if ((state_q == ST_HALT) && resume) begin
                state_d = ST_RUN;
            end else begin
                state_d = state_q;
            end
        end
    end

    // State and issue registers; async reset drops any pending issue
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            valid_q   <= 1'b0;
            op_q      <= 2'b00;
            rd_q      <= 4'h0;
            rs1_q     <= 4'h0;
            rs2_q     <= 4'h0;
            ipc_q     <= {AW{1'b0}};
            illegal_q <= 1'b0;
            cnt_q     <= {CW{1'b0}};
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            ipc_q     <= ipc_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pc_en       = pc_en_s;
    assign issue_valid = valid_q;
    assign issue_op    = op_q;
    assign issue_rd    = rd_q;
    assign issue_rs1   = rs1_q;
    assign issue_rs2   = rs2_q;
    assign issue_pc    = ipc_q;
    assign halted      = (state_q == ST_HALT);
    assign illegal     = illegal_q;
    assign issued_cnt  = cnt_q;

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch/decode/issue stage directly downstream of the 4-bit program counter in the BFloat16 FPU datapath.
- Holds a 16-entry instruction store, reads the word addressed by the PC each cycle, and decodes it into opcode and register fields.
- Issues decoded operations to the FPU over a valid/ready handshake.
- Drives pc_en back to the counter to stall it under backpressure, HALT, or program load.

Parameters:
- IW, 16, instruction word width
- AW, 4, PC/address width (store depth 2**AW)
- CW, 8, width of the issued-instruction counter

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- pc_i  in  AW  current program counter value
- pc_en  out  1  enable to the program counter; advance when high
- prog_we  in  1  program-store write strobe
- prog_addr  in  AW  program-store write address
- prog_data  in  IW  program-store write data
- resume  in  1  single-cycle pulse; leaves HALT
- issue_valid  out  1  decoded instruction present
- issue_ready  in  1  FPU accepts the instruction
- issue_op  out  2  00 ADD, 01 SUB, 10 MUL
- issue_rd  out  4  destination register
- issue_rs1  out  4  source register 1
- issue_rs2  out  4  source register 2
- issue_pc  out  AW  PC of the issued instruction
- halted  out  1  high in HALT state
- illegal  out  1  sticky illegal-opcode flag
- issued_cnt  out  CW  saturating count of accepted issues

Behaviour:
- Instruction format: [15:13] opcode, [12:9] rd, [8:5] rs1, [4:1] rs2, [0] ignored.
- Opcodes: 000 NOP, 001 ADD, 010 SUB, 011 MUL, 111 HALT; 100/101/110 are ILLEGAL.
- Reset (reset_n low, asynchronous):
  - state RUN; issue_valid 0; all issue_* fields 0; halted 0; illegal 0; issued_cnt 0.
  - Store contents are not reset.
- States: RUN and HALT.
- slot_free = !issue_valid || issue_ready.
- pc_en (combinational) = (state == RUN) && slot_free && !prog_we.
- Fetch rule: on any edge with pc_en high, read store[pc_i] and decode it:
  - ADD/SUB/MUL: load the issue registers, issue_valid becomes 1, issue_pc = pc_i. Latency is 1 cycle from PC presentation to issue_valid.
  - NOP: issue_valid becomes 0 (or stays 0); PC advances.
  - ILLEGAL: treated as NOP and illegal set to 1; illegal clears only on reset.
  - HALT: no issue, issue_valid becomes 0, state goes to HALT. pc_en was high that cycle, so the PC ends at HALT address + 1.
- Edge with pc_en low:
  - If issue_valid && issue_ready, issue_valid becomes 0.
  - Otherwise all issue outputs hold stable.
- Handshake: a transfer occurs on an edge with issue_valid && issue_ready.
  - issue_* outputs must not change while issue_valid && !issue_ready.
  - Each transfer increments issued_cnt, which saturates at 2**CW - 1.
- HALT state:
  - pc_en = 0 and halted = 1.
  - A pending issue still completes when issue_ready is seen.
  - resume high moves the state to RUN on the next edge.
  - resume in RUN is ignored.
- Program write: when prog_we is high, store[prog_addr] <= prog_data and pc_en = 0, so no fetch occurs that cycle.
- PC wrap 15 -> 0 is owned by the counter; this block just reads pc_i.
- reset_n low mid-handshake drops issue_valid immediately (asynchronously); no transfer is counted.
- resume and HALT fetch on the same edge: HALT wins; a second resume is required.

Decomposition:
- Shared package fpu_isa_pkg holds:
  - opcode constants (OP_NOP, OP_ADD, OP_SUB, OP_MUL, OP_HALT)
  - field bit positions
  - FPU op encodings (FOP_ADD=00, FOP_SUB=01, FOP_MUL=10)
- One sub-module, instr_store: 16 x IW registers, synchronous write, combinational read, no reset.
- Decode, FSM and issue register stay in instr_fetch_unit.

Test Plan:
- Load 0:ADD r1,r2,r3; 1:SUB r4,r5,r6; 2:HALT; hold ready=1, counter at 0 -> ADD/SUB issued on consecutive cycles with issue_pc 0, 1; halted=1 and pc_en=0 after pc=3; issued_cnt=2.
- Backpressure: issue_ready=0 for 3 cycles while an ADD is pending -> pc_en=0 and outputs stable for 3 cycles; then ready=1 gives one transfer and the next fetch.
- NOP and ILLEGAL (opcode 101) at addresses 0 and 1, MUL at 2 -> no issue for 0 and 1, illegal=1 stays set, MUL issued with issue_pc=2.
- Run in HALT, pulse resume -> RUN on the next edge, pc_en=1, fetch continues at HALT address + 1; 15 -> 0 wrap fetches address 0.
- prog_we asserted during RUN -> pc_en=0 that cycle and no fetch; the rewritten word is seen on the later fetch.
- reset_n low while issue_valid=1 and ready=0 -> issue_valid=0, issued_cnt=0, illegal=0 asynchronously; after release, fetch resumes in RUN.
